// File: rtl/alu_ctrl_encoder.sv
// ID->EX stage: encodes a LEGv8 instruction into the registered ALU control word.
// Define ALU_CTRL_ILLEGAL_CNT_EN to add a saturating illegal-instruction counter.
module alu_ctrl_encoder #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [2:0]         ex_cntrl,
  output logic               ex_set_flags,
  output logic               ex_imm_sel,
  output logic               ex_valid,
  output logic               ex_illegal,
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  output logic [CNT_W-1:0]   illegal_cnt,
`endif
  output logic               flag_hazard
);

  localparam logic [2:0] CtrlPassB = 3'b000;
  localparam logic [2:0] CtrlAdd   = 3'b010;
  localparam logic [2:0] CtrlSub   = 3'b011;
  localparam logic [2:0] CtrlAnd   = 3'b100;
  localparam logic [2:0] CtrlEor   = 3'b110;

  logic [10:0] op11;
  logic [2:0]  dec_cntrl;
  logic        dec_set_flags;
  logic        dec_imm_sel;
  logic        dec_illegal;
  logic        dec_is_bcond;

  logic [2:0] ex_cntrl_q, ex_cntrl_d;
  logic       ex_set_flags_q, ex_set_flags_d;
  logic       ex_imm_sel_q, ex_imm_sel_d;
  logic       ex_valid_q, ex_valid_d;
  logic       ex_illegal_q, ex_illegal_d;
  logic       load_en;

  // Only [31:21] are decoded; the operand fields are irrelevant here.
  logic unused_instr;
  assign unused_instr = ^id_instr;

  assign op11 = id_instr[31:21];

  always_comb begin
    dec_cntrl     = CtrlPassB;
    dec_set_flags = 1'b0;
    dec_imm_sel   = 1'b0;
    dec_illegal   = 1'b0;
    dec_is_bcond  = 1'b0;
    case (op11)
      11'b10101011000: begin
        dec_cntrl     = CtrlAdd;
        dec_set_flags = 1'b1;
      end
      11'b11101011000: begin
        dec_cntrl     = CtrlSub;
        dec_set_flags = 1'b1;
      end
      11'b10001010000: dec_cntrl = CtrlAnd;
      11'b11001010000: dec_cntrl = CtrlEor;
      11'b11111000010, 11'b11111000000: begin
        dec_cntrl   = CtrlAdd;
        dec_imm_sel = 1'b1;
      end
      default: begin
        if (id_instr[31:22] == 10'b1001000100) begin
          dec_cntrl   = CtrlAdd;
          dec_imm_sel = 1'b1;
        end else if (id_instr[31:24] == 8'b01010100) begin
          dec_is_bcond = 1'b1;
        end else if ((id_instr[31:24] == 8'b10110100) ||
                     (id_instr[31:26] == 6'b000101) ||
                     (id_instr[31:26] == 6'b100101)) begin
          dec_cntrl = CtrlPassB;
        end else begin
          dec_illegal = 1'b1;
        end
      end
    endcase
  end

  // A B.cond must not read NZCV while the flag setter ahead of it is still in EX.
  assign flag_hazard = id_valid & dec_is_bcond & ex_valid_q & ex_set_flags_q;

  assign load_en = !flush && !stall && !flag_hazard;

  always_comb begin
    ex_cntrl_d     = ex_cntrl_q;
    ex_set_flags_d = ex_set_flags_q;
    ex_imm_sel_d   = ex_imm_sel_q;
    ex_valid_d     = ex_valid_q;
    ex_illegal_d   = ex_illegal_q;
    if (flush || (!stall && flag_hazard)) begin
      ex_cntrl_d     = CtrlPassB;
      ex_set_flags_d = 1'b0;
      ex_imm_sel_d   = 1'b0;
      ex_valid_d     = 1'b0;
      ex_illegal_d   = 1'b0;
    end else if (load_en) begin
      ex_cntrl_d     = id_valid ? dec_cntrl : CtrlPassB;
      ex_set_flags_d = id_valid & dec_set_flags;
      ex_imm_sel_d   = id_valid & dec_imm_sel;
      ex_valid_d     = id_valid;
      ex_illegal_d   = id_valid & dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_cntrl_q     <= CtrlPassB;
      ex_set_flags_q <= 1'b0;
      ex_imm_sel_q   <= 1'b0;
      ex_valid_q     <= 1'b0;
      ex_illegal_q   <= 1'b0;
    end else begin
      ex_cntrl_q     <= ex_cntrl_d;
      ex_set_flags_q <= ex_set_flags_d;
      ex_imm_sel_q   <= ex_imm_sel_d;
      ex_valid_q     <= ex_valid_d;
      ex_illegal_q   <= ex_illegal_d;
    end
  end

  assign ex_cntrl     = ex_cntrl_q;
  assign ex_set_flags = ex_set_flags_q;
  assign ex_imm_sel   = ex_imm_sel_q;
  assign ex_valid     = ex_valid_q;
  assign ex_illegal   = ex_illegal_q;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_cnt_q <= '0;
    end else if (load_en && id_valid && dec_illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
      illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end
  end

  assign illegal_cnt = illegal_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Scoreboard bench for alu_ctrl_encoder: the driver queues expectations, a negedge monitor checks.
// Build with ALU_CTRL_ILLEGAL_CNT_EN to also check the illegal-instruction counter.
module tb_alu_ctrl_encoder;

  logic        clk;
  logic        reset;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic [2:0]  ex_cntrl;
  logic        ex_set_flags;
  logic        ex_imm_sel;
  logic        ex_valid;
  logic        ex_illegal;
  logic        flag_hazard;
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [7:0]  illegal_cnt;
`endif

  alu_ctrl_encoder #(
    .INSTR_W(32),
    .CNT_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .stall       (stall),
    .flush       (flush),
    .ex_cntrl    (ex_cntrl),
    .ex_set_flags(ex_set_flags),
    .ex_imm_sel  (ex_imm_sel),
    .ex_valid    (ex_valid),
    .ex_illegal  (ex_illegal),
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    .illegal_cnt (illegal_cnt),
`endif
    .flag_hazard (flag_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction words.
  localparam logic [31:0] IAdds = 32'hAB020020;
  localparam logic [31:0] ISubs = 32'hEB020020;
  localparam logic [31:0] IAnd  = 32'h8A020020;
  localparam logic [31:0] IEor  = 32'hCA020020;
  localparam logic [31:0] ILdur = 32'hF8400020;
  localparam logic [31:0] IStur = 32'hF8000020;
  localparam logic [31:0] IAddi = 32'h91000420;
  localparam logic [31:0] ICbz  = 32'hB4000040;
  localparam logic [31:0] IB    = 32'h14000010;
  localparam logic [31:0] IBl   = 32'h94000010;
  localparam logic [31:0] IBlt  = 32'h5400000B;
  localparam logic [31:0] IBeq  = 32'h54000040;
  localparam logic [31:0] IIll  = 32'hFFFFFFFF;

  // Expected EX fields packed as {valid, illegal, set_flags, imm_sel, cntrl[2:0]}.
  localparam logic [6:0] XAdds = 7'b1010010;
  localparam logic [6:0] XSubs = 7'b1010011;
  localparam logic [6:0] XAnd  = 7'b1000100;
  localparam logic [6:0] XEor  = 7'b1000110;
  localparam logic [6:0] XMem  = 7'b1001010;
  localparam logic [6:0] XBr   = 7'b1000000;
  localparam logic [6:0] XIll  = 7'b1100000;
  localparam logic [6:0] XNone = 7'b0000000;

  typedef struct {
    int         cyc;
    bit         is_hz;
    logic [6:0] exp;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      logic [6:0] act;
      e = q.pop_front();
      if (e.is_hz) begin
        total++;
        if (flag_hazard !== e.exp[0]) begin
          bad++;
          $display("FAIL flag_hazard cyc=%0d actual=%b required=%b", cyc, flag_hazard, e.exp[0]);
        end
      end else begin
        act = {ex_valid, ex_illegal, ex_set_flags, ex_imm_sel, ex_cntrl};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL ex_fields cyc=%0d actual=%b required=%b", cyc, act, e.exp);
        end
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        total++;
        if (int'(illegal_cnt) != e.cnt) begin
          bad++;
          $display("FAIL illegal_cnt cyc=%0d actual=%0d required=%0d", cyc, illegal_cnt, e.cnt);
        end
`endif
      end
    end
  end

  // Drive one cycle of inputs; exp_hz is checked this cycle, exp_ex after the next edge.
  task automatic step(input logic [31:0] instr, input bit v, input bit st, input bit fl,
                      input bit rs, input logic [6:0] exp_ex, input bit exp_hz);
    exp_t e;
    id_instr = instr;
    id_valid = v;
    stall    = st;
    flush    = fl;
    reset    = rs;
    if (!rs) model_cnt = 0;
    else if (!st && !fl && exp_ex[6] && exp_ex[5] && model_cnt < 255) model_cnt++;
    e.cyc = cyc;     e.is_hz = 1'b1; e.exp = {6'b0, exp_hz}; e.cnt = 0;
    q.push_back(e);
    e.cyc = cyc + 1; e.is_hz = 1'b0; e.exp = exp_ex;         e.cnt = model_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    id_instr = '0;
    id_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    //   instr  v  st fl rs  ex     hz
    step(IAdds, 0, 0, 0, 0, XNone, 0);
    step(IAdds, 0, 0, 0, 0, XNone, 0);
    step(IAdds, 1, 0, 0, 1, XAdds, 0);
    // Two flag setters then B.LT: a single bubble.
    step(ISubs, 1, 0, 0, 1, XSubs, 0);
    step(IBlt,  1, 0, 0, 1, XNone, 1);
    step(IBlt,  1, 0, 0, 1, XBr,   0);
    // Stall holds AND for three cycles.
    step(IAnd,  1, 0, 0, 1, XAnd,  0);
    step(IEor,  1, 1, 0, 1, XAnd,  0);
    step(IEor,  1, 1, 0, 1, XAnd,  0);
    step(IEor,  1, 1, 0, 1, XAnd,  0);
    step(IEor,  1, 0, 0, 1, XEor,  0);
    // Flush overrides stall.
    step(ILdur, 1, 0, 0, 1, XMem,  0);
    step(IStur, 1, 1, 1, 1, XNone, 0);
    step(IStur, 1, 0, 0, 1, XMem,  0);
    step(IAddi, 1, 0, 0, 1, XMem,  0);
    step(ICbz,  1, 0, 0, 1, XBr,   0);
    step(IB,    1, 0, 0, 1, XBr,   0);
    step(IBl,   1, 0, 0, 1, XBr,   0);
    step(IIll,  1, 0, 0, 1, XIll,  0);
    step(IIll,  0, 0, 0, 1, XNone, 0);
    // Invalid B.cond behind a flag setter is not a hazard.
    step(ISubs, 1, 0, 0, 1, XSubs, 0);
    step(IBlt,  0, 0, 0, 1, XNone, 0);
    step(ISubs, 1, 0, 1, 1, XNone, 0);
    for (int i = 0; i < 300; i++) step(IIll, 1, 0, 0, 1, XIll, 0);
    // Reset while both hazard and stall are active.
    step(IAdds, 1, 0, 0, 1, XAdds, 0);
    step(IBeq,  1, 1, 0, 1, XAdds, 1);
    step(IBeq,  1, 1, 0, 0, XNone, 1);
    step(IBeq,  1, 0, 0, 1, XBr,   0);
    step(IIll,  1, 0, 0, 1, XIll,  0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
